// File: rtl/vsm_kbd_pkg.sv
// rtl/vsm_kbd_pkg.sv - shared types and helpers for the keypad encoder
package vsm_kbd_pkg;

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE,
    PRESS,
    HELD,
    RELEASE
  } kbd_state_t;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  // One-hot active-low column drive for a column index
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Lowest-numbered low row wins when several rows are pulled low
  function automatic logic [1:0] row_encode(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

endpackage

// File: rtl/vsm_keypad_encoder_if.sv
// rtl/vsm_keypad_encoder_if.sv - key code / strobe bundle toward the B register
interface vsm_keypad_encoder_if;

  logic [3:0] Kbd1;
  logic       LatchB;
  logic       KeyValid;

  modport master (output Kbd1, output LatchB, output KeyValid);
  modport slave  (input  Kbd1, input  LatchB, input  KeyValid);

endinterface

// File: rtl/vsm_sync2.sv
// rtl/vsm_sync2.sv - 4-bit two-flop synchronizer, resets to all ones
module vsm_sync2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Two back-to-back flops; idle (all ones) out of reset so no false press is seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vsm_keypad_encoder.sv
// rtl/vsm_keypad_encoder.sv - 4x4 keypad scanner, debouncer and key encoder
module vsm_keypad_encoder #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                        MainClk,
  input  logic                        ClearB,
  input  logic [3:0]                  KbdRow,
  output logic [3:0]                  KbdCol,
  vsm_keypad_encoder_if.master        kbd
);

  import vsm_kbd_pkg::*;

  localparam logic [3:0] SCAN_LAST = 4'(SCAN_DIV - 1);
  localparam logic [7:0] DEB       = 8'(DEBOUNCE_CYCLES);

  kbd_state_t state;
  logic [3:0] rs;
  logic [3:0] dwell;
  logic [3:0] pat;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic [1:0] col_idx;
  logic [1:0] col_next;
  logic [1:0] row_idx;
  logic       row_idle;
  logic       row_match;

  vsm_sync2 u_row_sync (
    .clk   (MainClk),
    .rst_n (ClearB),
    .d     (KbdRow),
    .q     (rs)
  );

  assign col_next  = col_idx + 2'd1;
  assign row_idle  = (rs == ROW_IDLE);
  assign row_match = (rs == pat);
  // Saturating step so the counter can never wrap past the threshold
  assign cnt_inc   = (cnt >= DEB) ? DEB : cnt + 8'd1;

  // Scan / debounce / hold state machine with registered keypad and strobe outputs
  always_ff @(posedge MainClk or negedge ClearB) begin
    if (!ClearB) begin
      state        <= SCAN;
      col_idx      <= 2'd0;
      row_idx      <= 2'd0;
      dwell        <= 4'd0;
      cnt          <= 8'd0;
      pat          <= ROW_IDLE;
      KbdCol       <= col_drive(2'd0);
      kbd.Kbd1     <= 4'd0;
      kbd.LatchB   <= 1'b0;
      kbd.KeyValid <= 1'b0;
    end else begin
      kbd.LatchB <= 1'b0;
      case (state)
        SCAN: begin
          // Rows are only trusted on the last dwell cycle, after the synchronizer settles
          if (dwell == SCAN_LAST) begin
            dwell <= 4'd0;
            if (!row_idle) begin
              row_idx <= row_encode(rs);
              pat     <= rs;
              cnt     <= 8'd0;
              state   <= DEBOUNCE;
            end else begin
              col_idx <= col_next;
              KbdCol  <= col_drive(col_next);
            end
          end else begin
            dwell <= dwell + 4'd1;
          end
        end
        DEBOUNCE: begin
          if (row_match) begin
            cnt <= cnt_inc;
            if (cnt_inc == DEB) begin
              state        <= PRESS;
              kbd.Kbd1     <= {row_idx, col_idx};
              kbd.LatchB   <= 1'b1;
              kbd.KeyValid <= 1'b1;
            end
          end else begin
            state   <= SCAN;
            col_idx <= col_next;
            KbdCol  <= col_drive(col_next);
          end
        end
        PRESS: begin
          state <= HELD;
        end
        HELD: begin
          // Other non-idle patterns while held are deliberately ignored
          if (row_idle) begin
            cnt   <= 8'd0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!row_idle) begin
            state <= HELD;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == DEB) begin
              kbd.KeyValid <= 1'b0;
              state        <= SCAN;
              col_idx      <= col_next;
              KbdCol       <= col_drive(col_next);
            end
          end
        end
        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vsm_keypad_encoder.sv
// tb/tb_vsm_keypad_encoder.sv - randomized self-checking bench for vsm_keypad_encoder
module tb_vsm_keypad_encoder;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 4;

  logic        MainClk = 1'b0;
  logic        ClearB  = 1'b1;
  logic [15:0] key_mask = 16'd0;
  logic [3:0]  KbdRow;
  logic [3:0]  KbdCol;

  int checks = 0;
  int errors = 0;

  vsm_keypad_encoder_if kif ();

  vsm_keypad_encoder #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .MainClk (MainClk),
    .ClearB  (ClearB),
    .KbdRow  (KbdRow),
    .KbdCol  (KbdCol),
    .kbd     (kif)
  );

  always #5 MainClk = ~MainClk;

  // Keypad: key (r,c) pressed pulls row r low while column c is driven low
  function automatic logic [3:0] pads(input logic [3:0] col, input logic [15:0] mask);
    logic [3:0] r;
    r = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (!col[cc] && mask[rr*4+cc]) r[rr] = 1'b0;
    return r;
  endfunction

  assign KbdRow = pads(KbdCol, key_mask);

  function automatic logic [3:0] one_cold(input int c);
    logic [3:0] v;
    v = 4'b1111;
    v[c[1:0]] = 1'b0;
    return v;
  endfunction

  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    logic [1:0] v;
    v = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!r[i]) v = i[1:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge MainClk);
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_kbdcol   = 4'b1110;
  logic [3:0] m_kbd1     = 4'd0;
  logic       m_latchb   = 1'b0;
  logic       m_keyvalid = 1'b0;
  logic [3:0] h0 = 4'hF;
  logic [3:0] h1 = 4'hF;
  int         m_strobes = 0;

  task automatic tick(output logic [3:0] rs, output bit ab);
    @(posedge MainClk);
    ab = !ClearB;
    rs = h1;
    h1 = h0;
    h0 = pads(m_kbdcol, key_mask);
  endtask

  task automatic run_model();
    int         col;
    int         n;
    logic [3:0] rs;
    logic [3:0] pat;
    logic [1:0] row;
    bit         ab;
    bit         ok;
    bit         released;
    col = 0;
    m_kbdcol = one_cold(0);
    forever begin
      for (int d = 0; d < SCAN_DIV; d++) begin
        tick(rs, ab);
        if (ab) return;
      end
      if (rs != 4'b1111) begin
        pat = rs;
        row = lowest_low(rs);
        ok  = 1'b1;
        for (int k = 0; k < DEB; k++) begin
          tick(rs, ab);
          if (ab) return;
          if (rs != pat) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          m_kbd1     = {row, col[1:0]};
          m_latchb   = 1'b1;
          m_keyvalid = 1'b1;
          m_strobes++;
          tick(rs, ab);
          if (ab) return;
          m_latchb = 1'b0;
          released = 1'b0;
          while (!released) begin
            do begin
              tick(rs, ab);
              if (ab) return;
            end while (rs != 4'b1111);
            n = 0;
            while (n < DEB) begin
              tick(rs, ab);
              if (ab) return;
              if (rs != 4'b1111) break;
              n++;
            end
            released = (n == DEB);
          end
          m_keyvalid = 1'b0;
        end
      end
      col = (col + 1) % 4;
      m_kbdcol = one_cold(col);
    end
  endtask

  initial begin
    forever begin
      wait (ClearB === 1'b1);
      h0 = 4'hF;
      h1 = 4'hF;
      m_kbdcol   = 4'b1110;
      m_kbd1     = 4'd0;
      m_latchb   = 1'b0;
      m_keyvalid = 1'b0;
      run_model();
      wait (ClearB === 1'b0);
    end
  end

  // ---------------- per-cycle compare ----------------
  int         dut_strobes = 0;
  logic [3:0] last_code = 4'd0;
  logic       prev_latch = 1'b0;

  initial begin
    forever begin
      @(posedge MainClk);
      #2;
      if (ClearB) begin
        chk("KbdCol", 32'(KbdCol), 32'(m_kbdcol));
        chk("Kbd1", 32'(kif.Kbd1), 32'(m_kbd1));
        chk("LatchB", 32'(kif.LatchB), 32'(m_latchb));
        chk("KeyValid", 32'(kif.KeyValid), 32'(m_keyvalid));
      end else begin
        chk("rst_KbdCol", 32'(KbdCol), 32'(4'b1110));
        chk("rst_Kbd1", 32'(kif.Kbd1), 32'(4'd0));
        chk("rst_LatchB", 32'(kif.LatchB), 32'(1'b0));
        chk("rst_KeyValid", 32'(kif.KeyValid), 32'(1'b0));
      end
      chk("LatchB_back_to_back", 32'(kif.LatchB & prev_latch), 32'(1'b0));
      if (kif.LatchB === 1'b1) begin
        dut_strobes++;
        last_code = kif.Kbd1;
      end
      prev_latch = kif.LatchB;
    end
  end

  // Wait for the first cycle a given column is driven
  task automatic wait_col(input logic [3:0] v);
    logic [3:0] prev;
    bit         ok;
    ok   = 1'b0;
    prev = KbdCol;
    for (int n = 0; n < 200; n++) begin
      @(negedge MainClk);
      if (KbdCol == v && prev != v) begin
        ok = 1'b1;
        break;
      end
      prev = KbdCol;
    end
    chk("wait_col_timeout", 32'(ok), 32'(1'b1));
  endtask

  // ---------------- stimulus ----------------
  int base;
  int key;
  int hold;

  initial begin
    #1 ClearB = 1'b0;
    cyc(2);
    chk("init_KbdCol", 32'(KbdCol), 32'(4'b1110));
    chk("init_LatchB", 32'(kif.LatchB), 32'(1'b0));
    chk("init_KeyValid", 32'(kif.KeyValid), 32'(1'b0));
    cyc(1);
    ClearB = 1'b1;
    cyc(20);

    // clean press row1/col2
    base = dut_strobes;
    key_mask = 16'(1 << 6);
    cyc(100);
    chk("clean_keyvalid_held", 32'(kif.KeyValid), 32'(1'b1));
    key_mask = 16'd0;
    cyc(30);
    chk("clean_strobes", 32'(dut_strobes - base), 32'(1));
    chk("clean_code", 32'(last_code), 32'(4'b0110));
    chk("model_clean_code", 32'(m_kbd1), 32'(4'b0110));
    chk("clean_keyvalid_released", 32'(kif.KeyValid), 32'(1'b0));

    // bouncing press row2/col3
    base = dut_strobes;
    for (int i = 0; i < 10; i++) begin
      key_mask ^= 16'(1 << 11);
      cyc(2);
    end
    key_mask = 16'(1 << 11);
    cyc(80);
    key_mask = 16'd0;
    cyc(30);
    chk("bounce_strobes", 32'(dut_strobes - base), 32'(1));
    chk("bounce_code", 32'(last_code), 32'(4'b1011));

    // 3-cycle glitch on row0/col0
    base = dut_strobes;
    wait_col(4'b1110);
    key_mask = 16'(1 << 0);
    cyc(3);
    key_mask = 16'd0;
    cyc(5);
    chk("glitch_next_col", 32'(KbdCol), 32'(4'b1101));
    cyc(30);
    chk("glitch_strobes", 32'(dut_strobes - base), 32'(0));

    // rows 0 and 3 low together on col3
    base = dut_strobes;
    key_mask = 16'((1 << 3) | (1 << 15));
    cyc(60);
    key_mask = 16'd0;
    cyc(30);
    chk("multirow_strobes", 32'(dut_strobes - base), 32'(1));
    chk("multirow_code", 32'(last_code), 32'(4'b0011));

    // release bounce then second press row2/col1
    base = dut_strobes;
    key_mask = 16'(1 << 1);
    cyc(60);
    key_mask = 16'd0;
    cyc(2);
    key_mask = 16'(1 << 1);
    cyc(20);
    chk("relbounce_keyvalid", 32'(kif.KeyValid), 32'(1'b1));
    chk("relbounce_strobes", 32'(dut_strobes - base), 32'(1));
    key_mask = 16'd0;
    cyc(30);
    key_mask = 16'(1 << 9);
    cyc(60);
    key_mask = 16'd0;
    cyc(30);
    chk("second_press_strobes", 32'(dut_strobes - base), 32'(2));
    chk("second_press_code", 32'(last_code), 32'(4'b1001));

    // reset in the middle of debounce of row3/col0
    base = dut_strobes;
    wait_col(4'b1110);
    key_mask = 16'(1 << 12);
    cyc(6);
    ClearB = 1'b0;
    #1;
    chk("midrst_KbdCol", 32'(KbdCol), 32'(4'b1110));
    chk("midrst_Kbd1", 32'(kif.Kbd1), 32'(4'd0));
    chk("midrst_LatchB", 32'(kif.LatchB), 32'(1'b0));
    chk("midrst_KeyValid", 32'(kif.KeyValid), 32'(1'b0));
    key_mask = 16'd0;
    cyc(3);
    ClearB = 1'b1;
    cyc(40);
    chk("midrst_strobes", 32'(dut_strobes - base), 32'(0));

    // randomized presses, bounces, multi-key and short taps
    for (int it = 0; it < 40; it++) begin
      key = $urandom_range(0, 15);
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
        key_mask = 16'(1 << key);
        cyc($urandom_range(1, 3));
        key_mask = 16'd0;
        cyc($urandom_range(1, 3));
      end
      key_mask = 16'(1 << key);
      if ($urandom_range(0, 3) == 0) key_mask |= 16'(1 << $urandom_range(0, 15));
      hold = $urandom_range(3, 70);
      cyc(hold);
      key_mask = 16'd0;
      cyc($urandom_range(3, 40));
    end
    cyc(40);
    chk("strobe_total", 32'(dut_strobes), 32'(m_strobes));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
